// File: rtl/abro_pkg.sv
// Shared definitions for the ABRO front end and state machine: debounce state
// type, default conditioning parameters and the ABRO FSM state encoding.
package abro_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [0:0] {
    DEB_STABLE  = 1'b0,
    DEB_CONFIRM = 1'b1
  } deb_state_t;

  // ABRO state machine encoding, kept here so both blocks agree on it.
  localparam logic [1:0] ABRO_WAIT_AB = 2'd0;
  localparam logic [1:0] ABRO_WAIT_A  = 2'd1;
  localparam logic [1:0] ABRO_WAIT_B  = 2'd2;
  localparam logic [1:0] ABRO_DONE    = 2'd3;

  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/abro_input_conditioner_if.sv
// Bundle of the raw inputs, conditioned outputs and per-channel debounce state.
interface abro_input_conditioner_if;
  import abro_pkg::*;

  // Level/pulse signals only; no handshake. The conditioner samples A_raw/B_raw
  // every clock and presents A/B/A_rise/B_rise as valid on every cycle.
  logic       A_raw;
  logic       B_raw;
  logic       A;
  logic       B;
  logic       A_rise;
  logic       B_rise;
  deb_state_t A_state;
  deb_state_t B_state;

  modport master (
    output A_raw, B_raw,
    input  A, B, A_rise, B_rise, A_state, B_state
  );

  modport slave (
    input  A_raw, B_raw,
    output A, B, A_rise, B_rise, A_state, B_state
  );

endinterface

// File: rtl/abro_debounce_channel.sv
// One conditioning channel: synchronizer chain, two-state debounce FSM with a
// confirmation counter, and a registered rising-edge pulse.
module abro_debounce_channel
  import abro_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  output logic       level,
  output logic       rise,
  output deb_state_t state
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  // cnt counts consecutive samples of s that disagree with the accepted level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    case (state_q)
      DEB_STABLE: begin
        if (s != level_q) begin
          state_d = DEB_CONFIRM;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      DEB_CONFIRM: begin
        if (s == level_q) begin
          state_d = DEB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DEB_STABLE;
          cnt_d   = '0;
          level_d = s;
          rise_d  = s;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DEB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= DEB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign state = state_q;

endmodule

// File: rtl/abro_input_conditioner.sv
// Two independent debounce channels conditioning the A and B inputs of the
// ABRO state machine; this level is wiring only.
module abro_input_conditioner
  import abro_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                      clk,
  input logic                      rst_n,
  abro_input_conditioner_if.slave  io
);

  abro_debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (io.A_raw),
    .level (io.A),
    .rise  (io.A_rise),
    .state (io.A_state)
  );

  abro_debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (io.B_raw),
    .level (io.B),
    .rise  (io.B_rise),
    .state (io.B_state)
  );

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Bench for abro_input_conditioner: directed scenarios plus random toggling,
// checked every cycle against a run-length reference model via a scoreboard.
module tb_abro_input_conditioner;
  import abro_pkg::*;

  localparam int SYNC = SYNC_STAGES_DEF;
  localparam int DEB  = DEBOUNCE_CYCLES_DEF;
  localparam int LAT  = SYNC + DEB;
  localparam int W    = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  abro_input_conditioner_if io();

  abro_input_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int a_rises  = 0;
  int b_rises  = 0;
  logic [W-1:0] exp_q[$];

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  // s is the raw input delayed by SYNC edges; the level flips once DEB
  // consecutive samples of s disagree with it, any agreeing sample restarts the run.
  bit dq_a[$];
  bit dq_b[$];
  bit lvl_a, lvl_b;
  int run_a, run_b;

  function automatic void chan_step(input bit s, inout bit lvl, inout int run,
                                    output bit rise);
    rise = 1'b0;
    if (s != lvl) begin
      run++;
      if (run == DEB) begin
        rise = s;
        lvl  = s;
        run  = 0;
      end
    end else begin
      run = 0;
    end
  endfunction

  always @(posedge clk) begin
    bit sa, sb, ea, eb;
    ea = 1'b0;
    eb = 1'b0;
    if (!rst_n) begin
      lvl_a = 1'b0; lvl_b = 1'b0; run_a = 0; run_b = 0;
      dq_a.delete(); dq_b.delete();
      for (int i = 0; i < SYNC; i++) begin
        dq_a.push_back(1'b0);
        dq_b.push_back(1'b0);
      end
    end else begin
      sa = dq_a.pop_front(); dq_a.push_back(io.A_raw);
      sb = dq_b.pop_front(); dq_b.push_back(io.B_raw);
      chan_step(sa, lvl_a, run_a, ea);
      chan_step(sb, lvl_b, run_b, eb);
    end
    exp_q.push_back({lvl_a, lvl_b, ea, eb, run_a != 0, run_b != 0});
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    got = {io.A, io.B, io.A_rise, io.B_rise,
           io.A_state == DEB_CONFIRM, io.B_state == DEB_CONFIRM};
    if (io.A_rise === 1'b1) a_rises++;
    if (io.B_rise === 1'b1) b_rises++;
    if (exp_q.size() == 0) begin
      check(1'b0, "sb_empty", 32'(got), 32'hx);
    end else begin
      exp = exp_q.pop_front();
      check(got === exp, "outputs{A,B,Ar,Br,Ac,Bc}", 32'(got), 32'(exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_raw(input bit a, input bit b);
    io.A_raw = a;
    io.B_raw = b;
  endtask

  // Ticks until A reaches val; returns the number of ticks (bounded).
  task automatic wait_a(input bit val, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (io.A !== val && n < 40);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, ra, rb;
    set_raw(1'b1, 1'b1);

    // Reset held with both raw inputs high.
    tick(10);
    rst_n = 1'b1;
    wait_a(1'b1, n);
    check(n == LAT, "reset_release_latency", 32'(n), 32'(LAT));
    check(io.B === 1'b1, "reset_release_b_same_edge", 32'(io.B), 1);
    tick(3);
    check(a_rises == 1 && b_rises == 1, "reset_release_single_rises",
          32'(a_rises * 16 + b_rises), 32'h11);

    // Simultaneous fall, then simultaneous rise.
    ra = a_rises; rb = b_rises;
    set_raw(1'b0, 1'b0);
    wait_a(1'b0, n);
    check(n == LAT, "fall_latency", 32'(n), 32'(LAT));
    check(io.B === 1'b0, "fall_b_same_edge", 32'(io.B), 0);
    check(a_rises == ra && b_rises == rb, "fall_no_pulse", 32'(a_rises - ra + b_rises - rb), 0);
    tick(2);
    set_raw(1'b1, 1'b1);
    wait_a(1'b1, n);
    check(n == LAT, "dual_rise_latency", 32'(n), 32'(LAT));
    check(io.A_rise === 1'b1 && io.B_rise === 1'b1, "dual_rise_coincident",
          32'({io.A_rise, io.B_rise}), 32'h3);

    // Clean edge on A only.
    set_raw(1'b0, 1'b0);
    tick(12);
    rb = b_rises;
    io.A_raw = 1'b1;
    wait_a(1'b1, n);
    check(n == LAT, "clean_edge_latency", 32'(n), 32'(LAT));
    check(io.A_rise === 1'b1, "clean_edge_pulse", 32'(io.A_rise), 1);
    tick();
    check(io.A_rise === 1'b0, "clean_edge_pulse_width", 32'(io.A_rise), 0);
    check(io.B === 1'b0 && b_rises == rb, "clean_edge_b_quiet", 32'(io.B), 0);

    // Glitch rejection: DEB-1 cycles filtered, DEB cycles accepted.
    io.A_raw = 1'b0;
    tick(12);
    ra = a_rises;
    io.A_raw = 1'b1; tick(DEB - 1); io.A_raw = 1'b0; tick(12);
    check(a_rises == ra && io.A === 1'b0, "glitch_short_filtered", 32'(a_rises - ra), 0);
    io.A_raw = 1'b1; tick(DEB); io.A_raw = 1'b0; tick(15);
    check(a_rises == ra + 1, "glitch_min_width_accepted", 32'(a_rises - ra), 1);

    // Bounce: 1,0,1,1,0 then a stable high run.
    ra = a_rises;
    io.A_raw = 1'b1; tick(); io.A_raw = 1'b0; tick();
    io.A_raw = 1'b1; tick(); io.A_raw = 1'b1; tick();
    io.A_raw = 1'b0; tick();
    io.A_raw = 1'b1;
    wait_a(1'b1, n);
    check(n == LAT, "bounce_latency", 32'(n), 32'(LAT));
    tick(10);
    check(a_rises == ra + 1, "bounce_single_rise", 32'(a_rises - ra), 1);

    // Reset in the middle of a confirmation (cnt = 2).
    io.A_raw = 1'b0;
    tick(12);
    io.A_raw = 1'b1;
    tick(SYNC + 2);
    check(io.A_state === DEB_CONFIRM, "mid_confirm_reached", 32'(io.A_state), 1);
    rst_n = 1'b0;
    #1;
    check(io.A === 1'b0 && io.A_state === DEB_STABLE, "reset_abort_immediate",
          32'({io.A, io.A_state}), 0);
    tick(3);
    rst_n = 1'b1;
    wait_a(1'b1, n);
    check(n == LAT, "reset_abort_full_latency", 32'(n), 32'(LAT));

    // Random toggling with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) io.A_raw = ~io.A_raw;
      if ($urandom_range(0, 3) == 0) io.B_raw = ~io.B_raw;
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n = 1'b1;
    tick(20);
    check(exp_q.size() == 0, "sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
